// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Handshake bundle for the digit-serial adder/subtractor.
//   Request side : in_val/in_rdy with operands in_a, in_b, in_cin, in_sub.
//   Result side  : out_val/out_rdy with out_sum and out_cout.
//   master : the producer/consumer environment (drives requests, accepts results)
//   slave  : the adder itself
interface serial_adder_if #(
    parameter int NBITS = 16
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_val, in_a, in_b, in_cin, in_sub, out_rdy,
        input  in_rdy, out_val, out_sum, out_cout
    );

    modport slave (
        input  in_val, in_a, in_b, in_cin, in_sub, out_rdy,
        output in_rdy, out_val, out_sum, out_cout
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Digit-serial adder/subtractor. One DBITS-wide adder plus a registered
//   carry walks the operands LSB-first over NBITS/DBITS cycles.
//   Subtraction is A + ~B + 1 (carry forced to 1, cin ignored), so out_cout
//   reads 1 when no borrow occurred.
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : serial_adder_if.slave (request and result handshakes)
module serial_adder #(
    parameter int NBITS = 16,
    parameter int DBITS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    serial_adder_if.slave bus
);
    localparam int NDIG  = NBITS / DBITS;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [NBITS-1:0] sum_q, sum_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [DBITS:0]   dsum;

    // One digit of the addition; the extra top bit is the digit carry-out.
    assign dsum = {1'b0, a_q[DBITS-1:0]} + {1'b0, b_q[DBITS-1:0]}
                + {{DBITS{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (bus.in_val) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub | bus.in_cin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> DBITS;
                b_d     = b_q >> DBITS;
                // New digit enters at the top; after NDIG shifts the first
                // digit has reached bit 0. Written as shift/or so that
                // DBITS == NBITS needs no empty slice.
                sum_d   = (sum_q >> DBITS)
                        | (NBITS'(dsum[DBITS-1:0]) << (NBITS - DBITS));
                carry_d = dsum[DBITS];
                cout_d  = dsum[DBITS];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
        end
    end

    // Operand shift registers are fully reloaded on accept; no reset needed.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // in_rdy is gated by reset_n so it drops as soon as reset is asserted.
    assign bus.in_rdy   = reset_n && (state_q == IDLE);
    assign bus.out_val  = (state_q == DONE);
    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    logic clk;
    logic reset_n;

    int          cfg_sel;
    logic        drv_val;
    logic [31:0] drv_a;
    logic [31:0] drv_b;
    logic        drv_cin;
    logic        drv_sub;
    logic        drv_ordy;

    int nvec;
    int nerr;

    logic [63:0] exp_sum;
    logic [63:0] exp_cout;

    serial_adder_if #(.NBITS(16)) i0 ();
    serial_adder_if #(.NBITS(8))  i1 ();
    serial_adder_if #(.NBITS(8))  i2 ();
    serial_adder_if #(.NBITS(32)) i3 ();

    serial_adder #(.NBITS(16), .DBITS(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(i0.slave));
    serial_adder #(.NBITS(8),  .DBITS(8)) dut1 (.clk(clk), .reset_n(reset_n), .bus(i1.slave));
    serial_adder #(.NBITS(8),  .DBITS(1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(i2.slave));
    serial_adder #(.NBITS(32), .DBITS(8)) dut3 (.clk(clk), .reset_n(reset_n), .bus(i3.slave));

    assign i0.in_val = drv_val && (cfg_sel == 0);
    assign i1.in_val = drv_val && (cfg_sel == 1);
    assign i2.in_val = drv_val && (cfg_sel == 2);
    assign i3.in_val = drv_val && (cfg_sel == 3);
    assign i0.out_rdy = drv_ordy && (cfg_sel == 0);
    assign i1.out_rdy = drv_ordy && (cfg_sel == 1);
    assign i2.out_rdy = drv_ordy && (cfg_sel == 2);
    assign i3.out_rdy = drv_ordy && (cfg_sel == 3);
    assign i0.in_a = drv_a[15:0];
    assign i1.in_a = drv_a[7:0];
    assign i2.in_a = drv_a[7:0];
    assign i3.in_a = drv_a;
    assign i0.in_b = drv_b[15:0];
    assign i1.in_b = drv_b[7:0];
    assign i2.in_b = drv_b[7:0];
    assign i3.in_b = drv_b;
    assign i0.in_cin = drv_cin;
    assign i1.in_cin = drv_cin;
    assign i2.in_cin = drv_cin;
    assign i3.in_cin = drv_cin;
    assign i0.in_sub = drv_sub;
    assign i1.in_sub = drv_sub;
    assign i2.in_sub = drv_sub;
    assign i3.in_sub = drv_sub;

    logic        obs_val;
    logic        obs_rdy;
    logic        obs_cout;
    logic [31:0] obs_sum;

    always_comb begin
        obs_val  = 1'b0;
        obs_rdy  = 1'b0;
        obs_cout = 1'b0;
        obs_sum  = '0;
        case (cfg_sel)
            0: begin obs_val = i0.out_val; obs_rdy = i0.in_rdy; obs_cout = i0.out_cout; obs_sum = 32'(i0.out_sum); end
            1: begin obs_val = i1.out_val; obs_rdy = i1.in_rdy; obs_cout = i1.out_cout; obs_sum = 32'(i1.out_sum); end
            2: begin obs_val = i2.out_val; obs_rdy = i2.in_rdy; obs_cout = i2.out_cout; obs_sum = 32'(i2.out_sum); end
            default: begin obs_val = i3.out_val; obs_rdy = i3.in_rdy; obs_cout = i3.out_cout; obs_sum = i3.out_sum; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nb(input int c);
        case (c)
            0: return 16;
            1: return 8;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int db(input int c);
        case (c)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Golden model: plain N-bit arithmetic, subtraction as A + (2^N - B).
    task automatic set_exp(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub);
        logic [63:0] mask;
        logic [63:0] t;
        mask = (64'd1 << nb(c)) - 64'd1;
        if (sub) t = (64'(a) & mask) + ((~64'(b) & mask) + 64'd1);
        else     t = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
        exp_sum  = t & mask;
        exp_cout = (t >> nb(c)) & 64'd1;
    endtask

    task automatic start_op(input int c, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
        int n;
        cfg_sel = c;
        set_exp(c, a, b, cin, sub);
        drv_a   = a;
        drv_b   = b;
        drv_cin = cin;
        drv_sub = sub;
        drv_val = 1'b1;
        n = 0;
        while (!obs_rdy && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", 64'(obs_rdy), 64'd1);
        tick();
        drv_val = 1'b0;
        chk("rdy_low_calc", 64'(obs_rdy), 64'd0);
    endtask

    // Called one cycle after the accept edge; counts edges until out_val.
    task automatic wait_done(input string tag);
        int n;
        n = 1;
        while (!obs_val && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(nb(cfg_sel) / db(cfg_sel) + 1));
        chk({tag, "_sum"}, 64'(obs_sum), exp_sum);
        chk({tag, "_cout"}, 64'(obs_cout), exp_cout);
    endtask

    task automatic release_out(input string tag, input int stall);
        drv_ordy = 1'b0;
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({tag, "_hold_val"}, 64'(obs_val), 64'd1);
            chk({tag, "_hold_sum"}, 64'(obs_sum), exp_sum);
            chk({tag, "_hold_cout"}, 64'(obs_cout), exp_cout);
        end
        drv_ordy = 1'b1;
        tick();
        drv_ordy = 1'b0;
        chk({tag, "_val_drop"}, 64'(obs_val), 64'd0);
        chk({tag, "_rdy_back"}, 64'(obs_rdy), 64'd1);
    endtask

    task automatic full_op(input string tag, input int c, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic sub,
                           input int stall);
        start_op(c, a, b, cin, sub);
        wait_done(tag);
        release_out(tag, stall);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        nvec     = 0;
        nerr     = 0;
        cfg_sel  = 0;
        reset_n  = 1'b0;
        drv_val  = 1'b0;
        drv_a    = '0;
        drv_b    = '0;
        drv_cin  = 1'b0;
        drv_sub  = 1'b0;
        drv_ordy = 1'b0;

        // Reset state
        #2;
        chk("rst_rdy", 64'(obs_rdy), 64'd0);
        chk("rst_val", 64'(obs_val), 64'd0);
        chk("rst_sum", 64'(obs_sum), 64'd0);
        chk("rst_cout", 64'(obs_cout), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_rdy", 64'(obs_rdy), 64'd1);

        // Directed cases, 16/4
        full_op("add_basic", 0, 32'h1234, 32'h4321, 1'b0, 1'b0, 0);
        full_op("ripple_b1", 0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 0);
        full_op("ripple_cin", 0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 0);
        full_op("sub_neg_c0", 0, 32'h0005, 32'h0007, 1'b0, 1'b1, 0);
        full_op("sub_neg_c1", 0, 32'h0005, 32'h0007, 1'b1, 1'b1, 0);
        full_op("sub_pos_c0", 0, 32'h0007, 32'h0005, 1'b0, 1'b1, 0);
        full_op("sub_pos_c1", 0, 32'h0007, 32'h0005, 1'b1, 1'b1, 0);
        full_op("sub_zero", 0, 32'h1234, 32'h0000, 1'b0, 1'b1, 0);

        // Back-pressure with a competing request held during DONE
        start_op(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
        wait_done("bp_first");
        drv_a    = 32'h0F0F;
        drv_b    = 32'h0101;
        drv_cin  = 1'b1;
        drv_sub  = 1'b0;
        drv_val  = 1'b1;
        drv_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_val", 64'(obs_val), 64'd1);
            chk("bp_hold_sum", 64'(obs_sum), exp_sum);
            chk("bp_hold_cout", 64'(obs_cout), exp_cout);
            chk("bp_hold_rdy", 64'(obs_rdy), 64'd0);
        end
        drv_ordy = 1'b1;
        tick();
        drv_ordy = 1'b0;
        chk("bp_idle_val", 64'(obs_val), 64'd0);
        chk("bp_idle_rdy", 64'(obs_rdy), 64'd1);
        set_exp(0, 32'h0F0F, 32'h0101, 1'b1, 1'b0);
        tick();
        drv_val = 1'b0;
        chk("bp_accepted", 64'(obs_rdy), 64'd0);
        wait_done("bp_second");
        release_out("bp_second", 0);

        // Reset during CALC digit 2
        start_op(0, 32'hABCD, 32'h1357, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_val", 64'(obs_val), 64'd0);
        chk("midrst_sum", 64'(obs_sum), 64'd0);
        chk("midrst_rdy", 64'(obs_rdy), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_rdy_back", 64'(obs_rdy), 64'd1);
        chk("midrst_val_low", 64'(obs_val), 64'd0);
        full_op("after_rst", 0, 32'h0001, 32'h0001, 1'b0, 1'b0, 0);

        // Parameter sweep: boundary ripple then randomized back-to-back ops
        for (int c = 0; c < 4; c++) begin
            full_op("sweep_ripple", c, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
            full_op("sweep_subeq", c, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1'b1, 0);
            for (int i = 0; i < 12; i++) begin
                ra = $urandom;
                rb = $urandom;
                full_op("rand", c, ra, rb, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
